vga_buf_arbiter: RTL and testbench

- Owns the 4096x8 VGA character buffer and arbitrates its single RAM port between two requesters: CPU MMIO writes (MemType == VGA_INFO) and the VGA scanout reader.
- CPU writes never stall the CPU. They are posted into a small FIFO and drained on cycles the scanner leaves idle.
- A starvation guard forces a drain slot when the scanner monopolises the port.
- Sits between the top-level MMIO write decode and the VGA scan logic. It replaces the direct vga_info array.

---
 rtl/vga_buf_arbiter.sv | 150 +++++++++++++++
 tb/tb_vga_buf_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/vga_buf_arbiter.sv
// ---------------------------------------------------------------------------
// vga_buf_arbiter
//   Owns the VGA character buffer (2**ADDR_W x DATA_W) and shares its single
//   RAM port between posted CPU MMIO writes and the VGA scanout reader.
//   CPU writes never stall. They are queued in a small FIFO and drained on
//   cycles the scanner leaves idle. A starvation guard forces a drain slot
//   once the FIFO has waited MAX_WAIT cycles.
//
// Handshakes:
//   CPU side is fire-and-forget. i_cpu_we is a one-cycle strobe. A write that
//   finds the FIFO full with no pop that cycle is discarded, and o_cpu_drop
//   pulses on the following cycle. Scanner side is valid/ready style.
//   i_scan_req/i_scan_addr are held stable until o_scan_gnt is high in the
//   same cycle. Data returns one cycle later with o_scan_rvalid.
//
// Ports:
//   i_clock, i_reset_n     clock, synchronous active-low reset
//   i_cpu_we/addr/wdata    posted CPU write
//   o_cpu_full             FIFO full (from registered count)
//   o_cpu_drop             pulse one cycle after a discarded write
//   i_scan_req/addr        scanner read request
//   o_scan_gnt             request accepted this cycle (combinational)
//   o_scan_rvalid/rdata    registered read return; rdata holds when idle
//   o_fifo_level           current FIFO occupancy
//   o_last_owner           debug: owner of the RAM port last cycle
// ---------------------------------------------------------------------------
module vga_buf_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 8
) (
    input  logic                          i_clock,
    input  logic                          i_reset_n,
    input  logic                          i_cpu_we,
    input  logic [ADDR_W-1:0]             i_cpu_addr,
    input  logic [DATA_W-1:0]             i_cpu_wdata,
    output logic                          o_cpu_full,
    output logic                          o_cpu_drop,
    input  logic                          i_scan_req,
    input  logic [ADDR_W-1:0]             i_scan_addr,
    output logic                          o_scan_gnt,
    output logic                          o_scan_rvalid,
    output logic [DATA_W-1:0]             o_scan_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic [1:0]                    o_last_owner
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_MAX_C = WAIT_W'(MAX_WAIT);

    // Port owner encoding, debug only
    localparam logic [1:0] OWN_IDLE  = 2'd0;
    localparam logic [1:0] OWN_SCAN  = 2'd1;
    localparam logic [1:0] OWN_WRITE = 2'd2;

    logic [DATA_W-1:0] r_mem       [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] r_fifo_addr [0:FIFO_DEPTH-1];
    logic [DATA_W-1:0] r_fifo_data [0:FIFO_DEPTH-1];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [WAIT_W-1:0] r_wait;
    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata;
    logic              r_drop;
    logic [1:0]        r_owner;

    logic w_nonempty;
    logic w_force;
    logic w_gnt;
    logic w_pop;
    logic w_push;

    // Arbitration. Everything is qualified by reset so that nothing is
    // granted and no RAM write happens while reset is asserted.
    assign w_nonempty = (r_count != '0);
    assign w_force    = w_nonempty && (r_wait >= WAIT_MAX_C);
    assign w_gnt      = i_reset_n && i_scan_req && !w_force;
    assign w_pop      = i_reset_n && w_nonempty && !w_gnt;
    // A full FIFO still accepts a write in a cycle that frees a slot.
    assign w_push     = i_reset_n && i_cpu_we && ((r_count < DEPTH_C) || w_pop);

    // FIFO control, wait counter, read return, debug owner
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_wait   <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_drop   <= 1'b0;
            r_owner  <= OWN_IDLE;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            // Counts how long the head entry has waited; saturates so the
            // force condition stays asserted until a pop happens.
            if (w_pop || !w_nonempty)
                r_wait <= '0;
            else if (r_wait < WAIT_MAX_C)
                r_wait <= r_wait + WAIT_W'(1);

            r_rvalid <= w_gnt;
            // No forwarding: a read sees RAM before this cycle's pop lands.
            if (w_gnt) r_rdata <= r_mem[i_scan_addr];

            r_drop <= i_cpu_we && !w_push;

            if (w_gnt)      r_owner <= OWN_SCAN;
            else if (w_pop) r_owner <= OWN_WRITE;
            else            r_owner <= OWN_IDLE;
        end
    end

    // FIFO storage; contents are don't-care when not counted
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= i_cpu_addr;
            r_fifo_data[r_wr_ptr] <= i_cpu_wdata;
        end
    end

    // Character buffer write port; contents survive reset
    always_ff @(posedge i_clock) begin
        if (w_pop) r_mem[r_fifo_addr[r_rd_ptr]] <= r_fifo_data[r_rd_ptr];
    end

    assign o_cpu_full    = (r_count == DEPTH_C);
    assign o_cpu_drop    = r_drop;
    assign o_scan_gnt    = w_gnt;
    assign o_scan_rvalid = r_rvalid;
    assign o_scan_rdata  = r_rdata;
    assign o_fifo_level  = r_count;
    assign o_last_owner  = r_owner;

endmodule

// File: tb/tb_vga_buf_arbiter.sv
module tb_vga_buf_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int MAXW   = 8;

    // ---------------- clock / reset ----------------
    logic i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    logic              i_reset_n;
    logic              i_cpu_we;
    logic [ADDR_W-1:0] i_cpu_addr;
    logic [DATA_W-1:0] i_cpu_wdata;
    logic              o_cpu_full;
    logic              o_cpu_drop;
    logic              i_scan_req;
    logic [ADDR_W-1:0] i_scan_addr;
    logic              o_scan_gnt;
    logic              o_scan_rvalid;
    logic [DATA_W-1:0] o_scan_rdata;
    logic [2:0]        o_fifo_level;
    logic [1:0]        o_last_owner;

    vga_buf_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .MAX_WAIT(MAXW)
    ) dut (
        .i_clock(i_clock), .i_reset_n(i_reset_n),
        .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr), .i_cpu_wdata(i_cpu_wdata),
        .o_cpu_full(o_cpu_full), .o_cpu_drop(o_cpu_drop),
        .i_scan_req(i_scan_req), .i_scan_addr(i_scan_addr), .o_scan_gnt(o_scan_gnt),
        .o_scan_rvalid(o_scan_rvalid), .o_scan_rdata(o_scan_rdata),
        .o_fifo_level(o_fifo_level), .o_last_owner(o_last_owner)
    );

    // ---------------- reference model ----------------
    // Posted writes waiting to land, {addr, data}, oldest first.
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] m_mem   [0:(1<<ADDR_W)-1];
    bit                m_known [0:(1<<ADDR_W)-1];
    int                m_wait     = 0;
    bit                m_rvalid   = 0;
    logic [DATA_W-1:0] m_rdata    = '0;
    bit                m_rdata_ok = 0;
    bit                m_drop     = 0;
    bit                chk_en     = 0;

    int checks = 0;
    int errors = 0;

    // ---------------- scoreboard compare ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver: one clock cycle ----------------
    // Drives inputs, checks every output against the model's view of the
    // current cycle, advances the model, then moves past the next edge.
    task automatic cyc(input bit rn, input bit we, input logic [ADDR_W-1:0] wa,
                       input logic [DATA_W-1:0] wd, input bit req,
                       input logic [ADDR_W-1:0] ra);
        int sz;
        bit frc, gnt, pop, push;
        logic [ADDR_W+DATA_W-1:0] e;
        i_reset_n   = rn;
        i_cpu_we    = we;
        i_cpu_addr  = wa;
        i_cpu_wdata = wd;
        i_scan_req  = req;
        i_scan_addr = ra;
        #1;
        sz  = exp_q.size();
        frc = (sz != 0) && (m_wait >= MAXW);
        gnt = rn && req && !frc;
        pop = rn && (sz != 0) && !gnt;
        if (chk_en) begin
            chk("scan_gnt",    32'(o_scan_gnt),    32'(gnt));
            chk("cpu_full",    32'(o_cpu_full),    32'(sz == DEPTH));
            chk("fifo_level",  32'(o_fifo_level),  32'(sz));
            chk("scan_rvalid", 32'(o_scan_rvalid), 32'(m_rvalid));
            chk("cpu_drop",    32'(o_cpu_drop),    32'(m_drop));
            if (m_rdata_ok) chk("scan_rdata", 32'(o_scan_rdata), 32'(m_rdata));
        end
        if (!rn) begin
            exp_q.delete();
            m_wait     = 0;
            m_rvalid   = 0;
            m_rdata    = '0;
            m_rdata_ok = 1;
            m_drop     = 0;
        end else begin
            m_rvalid = gnt;
            if (gnt) begin
                m_rdata    = m_mem[ra];
                m_rdata_ok = m_known[ra];
            end
            if (pop) begin
                e = exp_q.pop_front();
                m_mem[e[ADDR_W+DATA_W-1:DATA_W]]   = e[DATA_W-1:0];
                m_known[e[ADDR_W+DATA_W-1:DATA_W]] = 1;
            end
            if (pop || sz == 0)    m_wait = 0;
            else if (m_wait < MAXW) m_wait = m_wait + 1;
            push = we && (sz < DEPTH || pop);
            if (push) exp_q.push_back({wa, wd});
            m_drop = we && !push;
        end
        @(posedge i_clock);
        #1;
        chk_en = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, '0, '0, 0, '0);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        bit pushed_full;

        // Reset with both requesters active: nothing granted
        cyc(0, 1, 12'h000, 8'h00, 1, 12'h000);
        cyc(0, 1, 12'h000, 8'h00, 1, 12'h000);
        chk("rst_level", 32'(o_fifo_level), 32'd0);
        chk("rst_rvalid", 32'(o_scan_rvalid), 32'd0);
        // First cycle out of reset: scanner granted
        cyc(1, 0, 12'h000, 8'h00, 1, 12'h000);

        // Idle scanner: write drains immediately, then read it back
        idle(2);
        cyc(1, 1, 12'h010, 8'h41, 0, 12'h000);
        idle(1);
        cyc(1, 0, 12'h000, 8'h00, 1, 12'h010);
        chk("idle_rd_valid", 32'(o_scan_rvalid), 32'd1);
        chk("idle_rd_data",  32'(o_scan_rdata),  32'h41);

        // Continuous scanning plus one write: forced slot after MAX_WAIT
        cyc(1, 1, 12'h030, 8'h55, 1, 12'h010);
        for (int i = 0; i < 14; i++) cyc(1, 0, '0, '0, 1, 12'h010);
        idle(2);

        // Fill with scanner busy; fifth write to 0x104 is dropped
        cyc(1, 1, 12'h104, 8'hEE, 0, 12'h000);
        idle(3);
        for (int i = 0; i < 5; i++)
            cyc(1, 1, 12'h100 + 12'(i), (i == 4) ? 8'h99 : 8'h60 + 8'(i), 1, 12'h010);
        chk("fill_full", 32'(o_cpu_full), 32'd1);

        // Write coinciding with the forced pop while full is accepted
        pushed_full = 0;
        for (int i = 0; i < 30 && !pushed_full; i++) begin
            if (exp_q.size() == DEPTH && m_wait >= MAXW) begin
                cyc(1, 1, 12'h200, 8'h77, 1, 12'h010);
                pushed_full = 1;
                chk("full_push_level", 32'(o_fifo_level), 32'd4);
                chk("full_push_drop",  32'(o_cpu_drop),   32'd0);
            end else begin
                cyc(1, 0, '0, '0, 1, 12'h010);
            end
        end
        chk("full_push_seen", 32'(pushed_full), 32'd1);
        idle(8);
        cyc(1, 0, '0, '0, 1, 12'h104);
        chk("drop_ram_kept", 32'(o_scan_rdata), 32'hEE);

        // Same-address ordering; read between the two pops sees the first
        cyc(1, 1, 12'h020, 8'h11, 0, 12'h000);
        cyc(1, 1, 12'h020, 8'h22, 0, 12'h000);
        cyc(1, 0, '0, '0, 1, 12'h020);
        chk("same_addr_first", 32'(o_scan_rdata), 32'h11);
        idle(1);
        cyc(1, 0, '0, '0, 1, 12'h020);
        chk("same_addr_last", 32'(o_scan_rdata), 32'h22);

        // Randomised traffic on a small address window, occasional reset
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 99) != 0),
                ($urandom_range(0, 1) == 1),
                12'($urandom_range(0, 15)),
                8'($urandom_range(0, 255)),
                ($urandom_range(0, 3) != 0),
                12'($urandom_range(0, 15)));
        end
        idle(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
